// File: rtl/memory_matrix_round_ctrl_pkg.sv
// Shared types and helpers for the memory-matrix round controller.
package memory_matrix_round_ctrl_pkg;

  // Widest board the one-hot helper accepts; narrower boards are zero-extended.
  localparam int MM_MAX_TILES = 32;

  // Round FSM states, 4-bit encoding.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START_WAIT = 4'd1,
    S_LOAD       = 4'd2,
    S_DISPLAY    = 4'd3,
    S_PLAY       = 4'd4,
    S_CHECK      = 4'd5,
    S_WIN        = 4'd6,
    S_LOSE       = 4'd7,
    S_END_WAIT   = 4'd8
  } mm_state_e;

  // Classification of an accepted guess.
  typedef enum logic [1:0] {
    G_INVALID = 2'd0,  // zero or more than one bit set
    G_HIT     = 2'd1,  // tile in solution, not yet revealed
    G_REPEAT  = 2'd2,  // tile already revealed
    G_MISS    = 2'd3   // tile not in solution
  } mm_gcls_e;

  // True when exactly one bit is set; bit scan only, no arithmetic on the board.
  function automatic logic is_onehot(input logic [MM_MAX_TILES-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MM_MAX_TILES; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

endpackage

// File: rtl/memory_matrix_round_ctrl_countdown.sv
// Preview timer: loadable down-counter with a terminal-count (zero) flag.
module memory_matrix_round_ctrl_countdown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; counting stops at zero so the flag stays asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/memory_matrix_round_ctrl.sv
// Round controller for the memory-matrix game: preview the solution, take
// one-hot guesses, reveal hits, spend budget on misses, report win/lose.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start press
// START_WAIT | start pressed, waiting for release
// LOAD       | latch solution and budget, arm the preview timer (1 cycle)
// DISPLAY    | show solution until the preview timer expires
// PLAY       | accept one guess strobe
// CHECK      | guess result visible; decide WIN / LOSE / PLAY
// WIN        | board complete, hold win and show solution
// LOSE       | budget exhausted, hold lose and show solution
// END_WAIT   | restart pressed, waiting for release
module memory_matrix_round_ctrl
  import memory_matrix_round_ctrl_pkg::*;
#(
  parameter int N_TILES        = 8,
  parameter int GUESS_W        = 4,
  parameter int MAX_GUESSES    = 8,
  parameter int DISPLAY_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_TILES-1:0] solution_board,
  input  logic [GUESS_W-1:0] guesses_init,
  input  logic [N_TILES-1:0] guess,
  input  logic               guess_valid,
  output logic               guess_ready,
  output logic [N_TILES-1:0] board_led,
  output logic [GUESS_W-1:0] guesses_left,
  output logic               hit,
  output logic               win,
  output logic               lose,
  output logic               busy
);

  localparam int TIMER_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD     = TIMER_W'(DISPLAY_CYCLES - 1);
  localparam logic [GUESS_W-1:0] BUDGET_DEFAULT = GUESS_W'(MAX_GUESSES);

  mm_state_e          state;
  mm_gcls_e           g_cls;
  logic [N_TILES-1:0] sol;
  logic [N_TILES-1:0] revealed;
  logic               timer_zero;

  memory_matrix_round_ctrl_countdown #(
    .WIDTH(TIMER_W)
  ) u_preview_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state == S_LOAD),
    .enable    (state == S_DISPLAY),
    .load_value(TIMER_LOAD),
    .zero      (timer_zero)
  );

  // Classify the presented guess against the latched solution and revealed set.
  always_comb begin
    g_cls = G_INVALID;
    if (is_onehot(MM_MAX_TILES'(guess))) begin
      if ((guess & sol) == '0)           g_cls = G_MISS;
      else if ((guess & revealed) != '0) g_cls = G_REPEAT;
      else                               g_cls = G_HIT;
    end
  end

  // Round FSM with board/budget registers; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      sol          <= '0;
      revealed     <= '0;
      guesses_left <= '0;
      board_led    <= '0;
      guess_ready  <= 1'b0;
      hit          <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_START_WAIT;
            busy  <= 1'b1;
          end
        end
        S_START_WAIT: begin
          if (!start) state <= S_LOAD;
        end
        S_LOAD: begin
          sol          <= solution_board;
          revealed     <= '0;
          guesses_left <= (guesses_init == '0) ? BUDGET_DEFAULT : guesses_init;
          board_led    <= solution_board;
          state        <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (timer_zero) begin
            state       <= S_PLAY;
            board_led   <= revealed;
            guess_ready <= 1'b1;
          end
        end
        S_PLAY: begin
          if (guess_valid) begin
            state       <= S_CHECK;
            guess_ready <= 1'b0;
            case (g_cls)
              G_HIT: begin
                revealed  <= revealed | guess;
                board_led <= revealed | guess;
                hit       <= 1'b1;
              end
              G_MISS: begin
                if (guesses_left != '0) guesses_left <= guesses_left - GUESS_W'(1);
              end
              default: ;
            endcase
          end
        end
        S_CHECK: begin
          // A completed board wins before an empty budget is considered.
          if (revealed == sol) begin
            state     <= S_WIN;
            win       <= 1'b1;
            board_led <= sol;
          end else if (guesses_left == '0) begin
            state     <= S_LOSE;
            lose      <= 1'b1;
            board_led <= sol;
          end else begin
            state       <= S_PLAY;
            guess_ready <= 1'b1;
          end
        end
        S_WIN, S_LOSE: begin
          if (start) begin
            state     <= S_END_WAIT;
            win       <= 1'b0;
            lose      <= 1'b0;
            board_led <= '0;
          end
        end
        S_END_WAIT: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_matrix_round_ctrl.sv
// Scoreboard bench: stimulus pushes every expected output change; a monitor
// pops one entry each time the observed output tuple changes.
module tb_memory_matrix_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] solution_board;
  logic [3:0] guesses_init;
  logic [7:0] guess;
  logic       guess_valid;
  logic       guess_ready;
  logic [7:0] board_led;
  logic [3:0] guesses_left;
  logic       hit, win, lose, busy;

  always #5 clk = ~clk;

  memory_matrix_round_ctrl #(
    .N_TILES(8), .GUESS_W(4), .MAX_GUESSES(8), .DISPLAY_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .solution_board(solution_board), .guesses_init(guesses_init),
    .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
    .board_led(board_led), .guesses_left(guesses_left),
    .hit(hit), .win(win), .lose(lose), .busy(busy)
  );

  // Expected tuple: board, left, {hit, win, lose, busy, ready}; hold = cycles
  // the previous tuple must have lasted (-1 = unchecked).
  typedef struct {
    string      name;
    logic [16:0] val;
    int         hold;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  logic [16:0] prev_out = '0;
  logic [16:0] cur_out;
  int          cyc = 0;
  int          last_cyc = 0;

  function automatic logic [16:0] outs();
    return {board_led, guesses_left, hit, win, lose, busy, guess_ready};
  endfunction

  task automatic ev(input string name, input logic [7:0] b, input logic [3:0] l,
                    input logic [4:0] flags, input int hold);
    exp_t e;
    e.name = name;
    e.val  = {b, l, flags};
    e.hold = hold;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h, required %h", name, act, req);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] g);
    guess       = g;
    guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Monitor: compare against the scoreboard on every change of the outputs.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        cur_out = outs();
        if (cur_out !== prev_out) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_change: actual %h, required unchanged %h", cur_out, prev_out);
          end else begin
            e_m = sb.pop_front();
            n_chk++;
            if (cur_out === e_m.val) n_pass++;
            else $display("FAIL %s: actual board=%h left=%0d hwlbr=%b, required board=%h left=%0d hwlbr=%b",
                          e_m.name, cur_out[16:9], cur_out[8:5], cur_out[4:0],
                          e_m.val[16:9], e_m.val[8:5], e_m.val[4:0]);
            if (e_m.hold >= 0) begin
              n_chk++;
              if ((cyc - last_cyc) == e_m.hold) n_pass++;
              else $display("FAIL %s_hold: actual %0d cycles, required %0d", e_m.name, cyc - last_cyc, e_m.hold);
            end
          end
          prev_out = cur_out;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; guess_valid = 1'b0; guess = '0;
    solution_board = '0; guesses_init = '0;
    repeat (3) step();
    chk("reset_state", outs(), 17'h0);
    mon_en = 1'b1;
    reset  = 1'b1;
    step();

    // Round A: preview length, four hits, win.
    solution_board = 8'hA5; guesses_init = 4'd3;
    ev("a_busy",    8'h00, 4'd3 & 4'd0, 5'b00010, -1);
    ev("a_preview", 8'hA5, 4'd3, 5'b00010, -1);
    ev("a_play",    8'h00, 4'd3, 5'b00011, 4);
    pulse_start();
    repeat (8) step();
    pulse_start();  // ignored in PLAY
    step();
    ev("a_hit01", 8'h01, 4'd3, 5'b10010, -1); ev("a_back01", 8'h01, 4'd3, 5'b00011, 1);
    strobe(8'h01);
    ev("a_hit04", 8'h05, 4'd3, 5'b10010, -1); ev("a_back04", 8'h05, 4'd3, 5'b00011, 1);
    strobe(8'h04);
    ev("a_hit20", 8'h25, 4'd3, 5'b10010, -1); ev("a_back20", 8'h25, 4'd3, 5'b00011, 1);
    strobe(8'h20);
    ev("a_hit80", 8'hA5, 4'd3, 5'b10010, -1); ev("a_win", 8'hA5, 4'd3, 5'b01010, 1);
    strobe(8'h80);
    ev("a_end_wait", 8'h00, 4'd3, 5'b00010, -1); ev("a_idle", 8'h00, 4'd3, 5'b00000, -1);
    pulse_start();
    step();

    // Round B: misses exhaust budget 2, strobe in DISPLAY and in LOSE dropped.
    solution_board = 8'h81; guesses_init = 4'd2;
    ev("b_busy",    8'h00, 4'd3, 5'b00010, -1);
    ev("b_preview", 8'h81, 4'd2, 5'b00010, -1);
    ev("b_play",    8'h00, 4'd2, 5'b00011, 4);
    pulse_start();
    step();
    strobe(8'h01);  // during DISPLAY
    repeat (4) step();
    ev("b_miss02", 8'h00, 4'd1, 5'b00010, -1); ev("b_back02", 8'h00, 4'd1, 5'b00011, 1);
    strobe(8'h02);
    ev("b_miss04", 8'h00, 4'd0, 5'b00010, -1); ev("b_lose", 8'h81, 4'd0, 5'b00110, 1);
    strobe(8'h04);
    strobe(8'h02);  // in LOSE: no budget wrap
    ev("b_end_wait", 8'h00, 4'd0, 5'b00010, -1); ev("b_idle", 8'h00, 4'd0, 5'b00000, -1);
    pulse_start();
    step();

    // Round C: invalid and repeated guesses, then async reset mid-round.
    solution_board = 8'hA5; guesses_init = 4'd5;
    ev("c_busy",    8'h00, 4'd0, 5'b00010, -1);
    ev("c_preview", 8'hA5, 4'd5, 5'b00010, -1);
    ev("c_play",    8'h00, 4'd5, 5'b00011, 4);
    pulse_start();
    repeat (7) step();
    ev("c_hit01", 8'h01, 4'd5, 5'b10010, -1); ev("c_back01", 8'h01, 4'd5, 5'b00011, 1);
    strobe(8'h01);
    ev("c_twobit", 8'h01, 4'd5, 5'b00010, -1); ev("c_back03", 8'h01, 4'd5, 5'b00011, 1);
    strobe(8'h03);
    ev("c_zero", 8'h01, 4'd5, 5'b00010, -1); ev("c_back00", 8'h01, 4'd5, 5'b00011, 1);
    strobe(8'h00);
    ev("c_repeat", 8'h01, 4'd5, 5'b00010, -1); ev("c_back_rep", 8'h01, 4'd5, 5'b00011, 1);
    strobe(8'h01);
    ev("c_hit04", 8'h05, 4'd5, 5'b10010, -1); ev("c_back04", 8'h05, 4'd5, 5'b00011, 1);
    strobe(8'h04);
    ev("c_reset", 8'h00, 4'd0, 5'b00000, -1);
    reset = 1'b0;
    #1;
    chk("async_reset", outs(), 17'h0);
    step();
    reset = 1'b1;
    step();

    // Round D: empty solution, zero init loads default budget, any strobe wins.
    solution_board = 8'h00; guesses_init = 4'd0;
    ev("d_busy",    8'h00, 4'd0, 5'b00010, -1);
    ev("d_preview", 8'h00, 4'd8, 5'b00010, -1);
    ev("d_play",    8'h00, 4'd8, 5'b00011, 4);
    pulse_start();
    repeat (7) step();
    ev("d_check", 8'h00, 4'd8, 5'b00010, -1); ev("d_win", 8'h00, 4'd8, 5'b01010, 1);
    strobe(8'h00);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL pending_events: actual %0d outstanding, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
